// File: rtl/la_trig_pkg.sv
// Shared types and config bit positions for the
// multi-channel logic-analyzer trigger.
package la_trig_pkg;

  localparam int CFG_W    = 4;
  localparam int CFG_RISE = 3;
  localparam int CFG_FALL = 2;
  localparam int CFG_HIGH = 1;
  localparam int CFG_LOW  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_QUAL  = 2'd2,
    ST_TRIGD = 2'd3
  } trig_st_e;

endpackage

// File: rtl/chan_match.sv
// One capture channel: input synchronizers, previous-sample
// registers and edge/level match against its config nibble.
module chan_match
  import la_trig_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ch_h,
  input  logic             ch_l,
  input  logic             smpl_en,
  input  logic [CFG_W-1:0] cfg,
  output logic             match,
  output logic             incl
);

  logic [1:0] h_sync;
  logic [1:0] l_sync;
  logic       prev_h;
  logic       prev_l;
  logic       cur_h;
  logic       cur_l;

  assign cur_h = h_sync[1];
  assign cur_l = l_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_sync <= '0;
      l_sync <= '0;
      prev_h <= 1'b0;
      prev_l <= 1'b0;
    end else begin
      h_sync <= {h_sync[0], ch_h};
      l_sync <= {l_sync[0], ch_l};
      // tracked in every state so edges are valid on the first armed strobe
      if (smpl_en) begin
        prev_h <= cur_h;
        prev_l <= cur_l;
      end
    end
  end

  assign match = (cfg[CFG_RISE] & ~prev_h & cur_h)
               | (cfg[CFG_FALL] & prev_l & ~cur_l)
               | (cfg[CFG_HIGH] & cur_h)
               | (cfg[CFG_LOW]  & ~cur_l);

  assign incl = |cfg;

endmodule

// File: rtl/multi_chan_trig.sv
// Multi-channel trigger: per-channel match, AND/OR combine,
// qualification counter and arm/trigger FSM.
module multi_chan_trig
  import la_trig_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int QUAL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_h,
  input  logic [NUM_CH-1:0]       ch_l,
  input  logic                    smpl_en,
  input  logic [CFG_W*NUM_CH-1:0] ch_cfg,
  input  logic                    ext_trig,
  input  logic                    ext_en,
  input  logic                    mode_or,
  input  logic [QUAL_W-1:0]       qual_len,
  input  logic                    arm,
  input  logic                    clr_trig,
  output logic                    armed,
  output logic                    triggered,
  output logic                    trig_pls,
  output logic [NUM_CH-1:0]       match_vec
);

  logic [NUM_CH-1:0] match_w;
  logic [NUM_CH-1:0] incl_w;
  trig_st_e          st;
  trig_st_e          st_n;
  logic [QUAL_W-1:0] cnt;
  logic [QUAL_W-1:0] cnt_n;
  logic              pls_n;
  logic              any_m;
  logic              all_m;
  logic              has_term;
  logic              comb;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    chan_match u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .ch_h    (ch_h[g]),
      .ch_l    (ch_l[g]),
      .smpl_en (smpl_en),
      .cfg     (ch_cfg[g*CFG_W +: CFG_W]),
      .match   (match_w[g]),
      .incl    (incl_w[g])
    );
  end

  assign any_m    = (|match_w) | (ext_en & ext_trig);
  assign all_m    = (&(match_w | ~incl_w)) & (~ext_en | ext_trig);
  assign has_term = (|incl_w) | ext_en;
  assign comb     = mode_or ? any_m : (has_term & all_m);

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    pls_n = 1'b0;
    if (clr_trig) begin
      st_n  = ST_IDLE;
      cnt_n = '0;
    end else begin
      unique case (1'b1)
        st == ST_IDLE: begin
          if (arm) begin
            st_n  = ST_ARMED;
            cnt_n = '0;
          end
        end
        st == ST_ARMED: begin
          if (smpl_en && comb) begin
            if (qual_len == '0) begin
              st_n  = ST_TRIGD;
              pls_n = 1'b1;
            end else begin
              st_n  = ST_QUAL;
              cnt_n = QUAL_W'(1);
            end
          end
        end
        st == ST_QUAL: begin
          if (smpl_en) begin
            if (!comb) begin
              st_n  = ST_ARMED;
              cnt_n = '0;
            end else if (cnt >= qual_len) begin
              st_n  = ST_TRIGD;
              pls_n = 1'b1;
            end else if (cnt != '1) begin
              cnt_n = cnt + QUAL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      cnt       <= '0;
      armed     <= 1'b0;
      triggered <= 1'b0;
      trig_pls  <= 1'b0;
      match_vec <= '0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      armed     <= (st_n == ST_ARMED) || (st_n == ST_QUAL);
      triggered <= (st_n == ST_TRIGD);
      trig_pls  <= pls_n;
      if (smpl_en) match_vec <= match_w;
    end
  end

endmodule

// File: tb/tb_multi_chan_trig.sv
// Self-checking bench for multi_chan_trig: expected trig_pls
// cycles are queued at stimulus time and matched by a monitor.
module tb_multi_chan_trig;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ch_h;
  logic [4:0]  ch_l;
  logic        smpl_en;
  logic [19:0] ch_cfg;
  logic        ext_trig;
  logic        ext_en;
  logic        mode_or;
  logic [7:0]  qual_len;
  logic        arm;
  logic        clr_trig;
  logic        armed;
  logic        triggered;
  logic        trig_pls;
  logic [4:0]  match_vec;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  multi_chan_trig #(.NUM_CH(5), .QUAL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_h      (ch_h),
    .ch_l      (ch_l),
    .smpl_en   (smpl_en),
    .ch_cfg    (ch_cfg),
    .ext_trig  (ext_trig),
    .ext_en    (ext_en),
    .mode_or   (mode_or),
    .qual_len  (qual_len),
    .arm       (arm),
    .clr_trig  (clr_trig),
    .armed     (armed),
    .triggered (triggered),
    .trig_pls  (trig_pls),
    .match_vec (match_vec)
  );

  // scoreboard: every trig_pls must match the next queued cycle
  always @(negedge clk) begin
    if (trig_pls === 1'b1) begin
      int e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_trig_pls cyc=%0d none expected", cyc);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e) begin
          errors++;
          $display("FAIL trig_pls_cycle got=%0d exp=%0d", cyc, e);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [4:0] h, input logic [4:0] l,
                       input logic xt, input bit exp_trig);
    if (exp_trig) exp_q.push_back(cyc + 3);
    ch_h = h;
    ch_l = l;
    ext_trig = xt;
    tick;
    tick;
    smpl_en = 1'b1;
    tick;
    smpl_en = 1'b0;
    ext_trig = 1'b0;
  endtask

  task automatic strobe(input bit exp_trig);
    if (exp_trig) exp_q.push_back(cyc + 1);
    smpl_en = 1'b1;
    tick;
    smpl_en = 1'b0;
    tick;
  endtask

  task automatic pulse_arm;
    arm = 1'b1;
    tick;
    arm = 1'b0;
  endtask

  task automatic pulse_clr;
    clr_trig = 1'b1;
    tick;
    clr_trig = 1'b0;
  endtask

  task automatic drain(input string name);
    tick;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_trig_pls pending=%0d exp=0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ch_h = '0; ch_l = '0; smpl_en = 1'b0; ch_cfg = '0;
    ext_trig = 1'b0; ext_en = 1'b0; mode_or = 1'b0;
    qual_len = '0; arm = 1'b0; clr_trig = 1'b0;
    tick; tick;
    checks++;
    if (armed !== 1'b0) begin
      errors++; $display("FAIL reset_armed got=%b exp=0", armed);
    end
    checks++;
    if (triggered !== 1'b0) begin
      errors++; $display("FAIL reset_trig got=%b exp=0", triggered);
    end
    checks++;
    if (trig_pls !== 1'b0) begin
      errors++; $display("FAIL reset_pls got=%b exp=0", trig_pls);
    end
    checks++;
    if (match_vec !== 5'b0) begin
      errors++; $display("FAIL reset_mvec got=%b exp=0", match_vec);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_rise;
    ch_cfg = 20'h00008;
    pulse_arm;
    checks++;
    if (armed !== 1'b1) begin
      errors++; $display("FAIL rise_armed got=%b exp=1", armed);
    end
    apply(5'b00001, 5'b00000, 1'b0, 1'b1);
    checks++;
    if (triggered !== 1'b1) begin
      errors++; $display("FAIL rise_trig got=%b exp=1", triggered);
    end
    checks++;
    if (match_vec !== 5'b00001) begin
      errors++; $display("FAIL rise_mvec got=%b exp=00001", match_vec);
    end
    checks++;
    if (armed !== 1'b0) begin
      errors++; $display("FAIL rise_armed_off got=%b exp=0", armed);
    end
    apply(5'b00001, 5'b00000, 1'b0, 1'b0);
    drain("rise");
    pulse_clr;
    checks++;
    if (triggered !== 1'b0) begin
      errors++; $display("FAIL rise_clr got=%b exp=0", triggered);
    end
  endtask

  task automatic test_and_levels;
    ch_cfg = 20'h00012;
    pulse_arm;
    apply(5'b00001, 5'b00010, 1'b0, 1'b0);
    checks++;
    if (match_vec !== 5'b00001 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL and_h_only mvec=%b trig=%b exp=00001/0",
               match_vec, triggered);
    end
    apply(5'b00000, 5'b00000, 1'b0, 1'b0);
    checks++;
    if (match_vec !== 5'b00010 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL and_l_only mvec=%b trig=%b exp=00010/0",
               match_vec, triggered);
    end
    apply(5'b00001, 5'b00000, 1'b0, 1'b1);
    checks++;
    if (match_vec !== 5'b00011 || triggered !== 1'b1) begin
      errors++;
      $display("FAIL and_both mvec=%b trig=%b exp=00011/1",
               match_vec, triggered);
    end
    drain("and_levels");
    pulse_clr;
  endtask

  task automatic test_or_ext;
    ch_cfg = '0;
    pulse_arm;
    apply(5'b11111, 5'b00000, 1'b0, 1'b0);
    checks++;
    if (triggered !== 1'b0 || armed !== 1'b1) begin
      errors++;
      $display("FAIL and_no_terms trig=%b armed=%b exp=0/1",
               triggered, armed);
    end
    mode_or = 1'b1;
    ext_en = 1'b1;
    apply(5'b11111, 5'b00000, 1'b0, 1'b0);
    checks++;
    if (triggered !== 1'b0) begin
      errors++; $display("FAIL or_ext_low got=%b exp=0", triggered);
    end
    apply(5'b11111, 5'b00000, 1'b1, 1'b1);
    checks++;
    if (triggered !== 1'b1) begin
      errors++; $display("FAIL or_ext_hit got=%b exp=1", triggered);
    end
    drain("or_ext");
    pulse_clr;
    mode_or = 1'b0;
    ext_en = 1'b0;
  endtask

  task automatic test_qual;
    ch_cfg = 20'h00002;
    qual_len = 8'd3;
    pulse_arm;
    for (int i = 0; i < 3; i++) apply(5'b00001, 5'b0, 1'b0, 1'b0);
    apply(5'b00000, 5'b0, 1'b0, 1'b0);
    checks++;
    if (triggered !== 1'b0 || armed !== 1'b1) begin
      errors++;
      $display("FAIL qual_3_short trig=%b armed=%b exp=0/1",
               triggered, armed);
    end
    for (int i = 0; i < 3; i++) apply(5'b00001, 5'b0, 1'b0, 1'b0);
    checks++;
    if (armed !== 1'b1) begin
      errors++; $display("FAIL qual_in_qual got=%b exp=1", armed);
    end
    apply(5'b00001, 5'b0, 1'b0, 1'b1);
    checks++;
    if (triggered !== 1'b1) begin
      errors++; $display("FAIL qual_4_hit got=%b exp=1", triggered);
    end
    drain("qual");
    pulse_clr;
  endtask

  task automatic test_qual_max;
    qual_len = 8'hFF;
    pulse_arm;
    for (int i = 0; i < 255; i++) strobe(1'b0);
    checks++;
    if (triggered !== 1'b0 || armed !== 1'b1) begin
      errors++;
      $display("FAIL qmax_early trig=%b armed=%b exp=0/1",
               triggered, armed);
    end
    strobe(1'b1);
    checks++;
    if (triggered !== 1'b1) begin
      errors++; $display("FAIL qmax_hit got=%b exp=1", triggered);
    end
    drain("qual_max");
    pulse_clr;
  endtask

  task automatic test_arm_clr;
    arm = 1'b1;
    clr_trig = 1'b1;
    tick;
    arm = 1'b0;
    clr_trig = 1'b0;
    checks++;
    if (armed !== 1'b0) begin
      errors++; $display("FAIL arm_clr_both got=%b exp=0", armed);
    end
    qual_len = 8'd3;
    pulse_arm;
    strobe(1'b0);
    strobe(1'b0);
    checks++;
    if (armed !== 1'b1) begin
      errors++; $display("FAIL midq_armed got=%b exp=1", armed);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({armed, triggered, trig_pls, match_vec} !== 8'b0) begin
      errors++;
      $display("FAIL midq_reset outs=%b exp=00000000",
               {armed, triggered, trig_pls, match_vec});
    end
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) apply(5'b00001, 5'b0, 1'b0, 1'b0);
    checks++;
    if (armed !== 1'b0 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL midq_after armed=%b trig=%b exp=0/0",
               armed, triggered);
    end
    drain("arm_clr");
  endtask

  task automatic test_back_to_back;
    ch_cfg = 20'h00008;
    qual_len = '0;
    pulse_arm;
    apply(5'b00000, 5'b0, 1'b0, 1'b0);
    apply(5'b00001, 5'b0, 1'b0, 1'b1);
    pulse_arm;
    checks++;
    if (triggered !== 1'b1 || armed !== 1'b0) begin
      errors++;
      $display("FAIL b2b_arm_ign trig=%b armed=%b exp=1/0",
               triggered, armed);
    end
    apply(5'b00000, 5'b0, 1'b0, 1'b0);
    apply(5'b00001, 5'b0, 1'b0, 1'b0);
    pulse_clr;
    checks++;
    if (triggered !== 1'b0 || armed !== 1'b0) begin
      errors++;
      $display("FAIL b2b_clr trig=%b armed=%b exp=0/0",
               triggered, armed);
    end
    pulse_arm;
    apply(5'b00000, 5'b0, 1'b0, 1'b0);
    apply(5'b00001, 5'b0, 1'b0, 1'b1);
    checks++;
    if (triggered !== 1'b1) begin
      errors++; $display("FAIL b2b_retrig got=%b exp=1", triggered);
    end
    drain("back_to_back");
  endtask

  initial begin
    test_reset;
    test_rise;
    test_and_levels;
    test_or_ext;
    test_qual;
    test_qual_max;
    test_arm_clr;
    test_back_to_back;
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_chan_trig.md
MULTI_CHAN_TRIG -- requirements
Module: multi_chan_trig

Interface
REQ-001 The block SHALL have the parameter NUM_CH, default 5, giving the number of capture channels (1..16).
REQ-002 The block SHALL have the parameter QUAL_W, default 8, giving the width of the qualification counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 clk  in  1  100MHz system clock; all logic on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 ch_h  in  NUM_CH  high-threshold comparator bits; asynchronous to clk.
REQ-007 ch_l  in  NUM_CH  low-threshold comparator bits; asynchronous to clk.
REQ-008 smpl_en  in  1  one-clk sample strobe; the block evaluates only on strobed cycles.
REQ-009 ch_cfg  in  4*NUM_CH  per-channel config. Bit 3 = rise on H, bit 2 = fall on L, bit 1 = high on H, bit 0 = low on L; 0000 = don't care.
REQ-010 ext_trig, ext_en  in  1 each  protocol-trigger match (UART/SPI) and its enable.
REQ-011 mode_or  in  1  0 = AND of all enabled terms, 1 = OR.
REQ-012 qual_len  in  QUAL_W  number of extra consecutive matching samples required.
REQ-013 arm, clr_trig  in  1 each  level-sampled control pulses.
REQ-014 armed  out  1  high in ARMED or QUAL.
REQ-015 triggered  out  1  sticky; high in TRIGD.
REQ-016 trig_pls  out  1  one-clk pulse on entry to TRIGD.
REQ-017 match_vec  out  NUM_CH  registered per-channel match from the last strobe.

Function
REQ-018 Each ch_h/ch_l bit SHALL pass through a 2-flop synchronizer before use.
REQ-019 The previous synchronized H/L SHALL be captured on every smpl_en, in all states, so edges are valid on the first armed sample.
REQ-020 Rise SHALL equal prev_H=0 and cur_H=1; fall SHALL equal prev_L=1 and cur_L=0, both evaluated at smpl_en.
REQ-021 A channel's match SHALL be the OR of its enabled conditions; a channel with cfg 0000 is excluded from combining.
REQ-022 In AND mode, combined = AND over included channels (and ext_trig if ext_en). With zero included terms, combined SHALL be 0.
REQ-023 In OR mode, combined = OR over included channels (and ext_trig if ext_en).
REQ-024 The FSM SHALL have states IDLE, ARMED, QUAL, TRIGD.
REQ-025 IDLE->ARMED on arm; the qualification count SHALL be cleared.
REQ-026 In ARMED, at smpl_en with combined=1: go to TRIGD if qual_len=0; otherwise go to QUAL with count=1.
REQ-027 In QUAL, at smpl_en with combined=1: increment the count; go to TRIGD when count equals qual_len.
REQ-028 In QUAL, at smpl_en with combined=0: return to ARMED and clear the count.
REQ-029 The count SHALL saturate and never wrap; qual_len = all-ones requires 2^QUAL_W-1 extra samples.
REQ-030 In ARMED or QUAL, clr_trig SHALL return the FSM to IDLE.
REQ-031 In TRIGD, clr_trig SHALL go to IDLE; arm SHALL be ignored.
REQ-032 When arm and clr_trig are asserted together, clr_trig SHALL win.
REQ-033 Cycles without smpl_en SHALL hold the FSM and counter state.
REQ-034 Latency: trig_pls SHALL assert on the clk after the qualifying smpl_en cycle. Channel input to trigger = 2 sync cycles + strobe + 1.
REQ-035 Changing ch_cfg or mode_or while armed SHALL take effect at the next strobe, without glitching outputs.

Reset
REQ-036 On rst_n low: FSM to IDLE; count, synchronizers and prev registers to 0; armed, triggered, trig_pls and match_vec to 0.
REQ-037 Reset asserted mid-qualification SHALL abandon the trigger; no trig_pls SHALL follow deassertion.

Structure
REQ-038 Package la_trig_pkg SHALL hold the state enum, the cfg bit indices (CFG_RISE=3, CFG_FALL=2, CFG_HIGH=1, CFG_LOW=0) and CFG_W=4.
REQ-039 Sub-module chan_match (sync, prev, edge/level match, include flag) SHALL be generated NUM_CH times; the FSM and combine logic stay top-level.

Verification
REQ-040 NUM_CH=5, AND mode, CH1 cfg 1000, others 0, qual_len 0, arm, CH1H 0->1 -> one trig_pls, triggered=1, match_vec=00001.
REQ-041 AND mode, CH1 cfg 0010, CH2 cfg 0001 -> no trigger with CH1H=1/CH2L=1 alone; trigger when CH1H=1 and CH2L=0 together.
REQ-042 OR mode, ext_en=1, all cfg 0, ext_trig pulse on a strobe -> trigger.
REQ-043 qual_len=3, CH1 high level; high for 3 strobes then low -> no trigger; high for 4 strobes -> trigger on 4th strobe +1 clk.
REQ-044 arm and clr_trig together -> stays IDLE. Reset mid-QUAL -> all outputs 0, no trig_pls afterwards.
REQ-045 TRIGD then arm -> triggered stays 1; clr_trig -> IDLE; re-arm re-triggers on the next match.
